// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: parametrised IEEE-754-style floating-point multiplier (flush-to-zero, 5 rounding modes).
// Latency 3 register stages (S1 unpack/multiply, S2 normalise/round, S3 pack into output regs); 1 op/cycle.
// Backpressure: every stage advances only when ~out_valid | out_ready, so a stalled output freezes the pipe.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready with r_mode, fp_X, fp_Y;
//        out_valid/out_ready with fp_Z and the ovrf/udrf flags (qualified by out_valid).
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           r_mode,
  input  logic [EXP_W+MAN_W:0] fp_X,
  input  logic [EXP_W+MAN_W:0] fp_Y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] fp_Z,
  output logic                 ovrf,
  output logic                 udrf
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;      // significand width incl. hidden bit
  localparam int PW = 2 * SW;         // full product width
  localparam int XW = EXP_W + 2;      // signed working exponent width
  localparam logic [XW-1:0]    BIAS_X = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic [XW-1:0]    EMAX_X = XW'((1 << EXP_W) - 1);
  localparam logic [XW-1:0]    ONE_X  = XW'(1);
  localparam logic [EXP_W-1:0] E_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] E_MAXF = E_ONES - 1'b1;
  localparam logic [W-1:0]     QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en & rst_n;

  // ---------------- S1: unpack, special detect, multiply ----------------
  logic             sx, sy;
  logic [EXP_W-1:0] ex, ey;
  logic [MAN_W-1:0] fx, fy;
  logic             x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
  logic             is_nan, is_inf, is_zero, sign;
  logic [W-1:0]     spec_z;
  logic             spec_ov, spec_ud;
  logic [XW-1:0]    exp_sum;
  logic [PW-1:0]    prod;

  assign {sx, ex, fx} = fp_X;
  assign {sy, ey, fy} = fp_Y;
  // Exponent field 0 covers denormals too: they are flushed to signed zero.
  assign x_zero  = (ex == '0);
  assign y_zero  = (ey == '0);
  assign x_inf   = (&ex) & ~(|fx);
  assign y_inf   = (&ey) & ~(|fy);
  assign x_nan   = (&ex) & (|fx);
  assign y_nan   = (&ey) & (|fy);
  assign is_nan  = x_nan | y_nan | (x_inf & y_zero) | (y_inf & x_zero);
  assign is_inf  = ~is_nan & (x_inf | y_inf);
  assign is_zero = ~is_nan & ~is_inf & (x_zero | y_zero);
  assign sign    = sx ^ sy;
  // Modulo-2^XW arithmetic; the result is read as signed downstream.
  assign exp_sum = XW'(ex) + XW'(ey) - BIAS_X;
  assign prod    = PW'({1'b1, fx}) * PW'({1'b1, fy});

  always_comb begin
    spec_z  = '0;
    spec_ov = 1'b0;
    spec_ud = 1'b0;
    if (is_nan) begin
      spec_z = QNAN;
    end else if (is_inf) begin
      spec_z  = {sign, E_ONES, {MAN_W{1'b0}}};
      spec_ov = 1'b1;
    end else if (is_zero) begin
      spec_z  = {sign, {(W - 1){1'b0}}};
      spec_ud = 1'b1;
    end
  end

  logic             s1_valid, s1_spec, s1_spec_ov, s1_spec_ud, s1_sign;
  logic [W-1:0]     s1_spec_z;
  logic [XW-1:0]    s1_exp;
  logic [PW-1:0]    s1_prod;
  logic [2:0]       s1_mode;

  // ---------------- S2: normalise, round ----------------
  logic             norm_shift, guard, rnd, sticky, inexact, inc, carry;
  logic [PW-1:0]    pn;
  logic [SW-1:0]    kept;
  logic [SW:0]      mant_r;
  logic [MAN_W-1:0] frac_r;
  logic [XW-1:0]    exp_r;

  // Product lies in [1,4); align so the leading one always sits at bit PW-1.
  assign norm_shift = s1_prod[PW-1];
  assign pn         = norm_shift ? s1_prod : {s1_prod[PW-2:0], 1'b0};
  assign kept       = pn[PW-1 -: SW];
  assign guard      = pn[MAN_W];
  assign rnd        = pn[MAN_W-1];
  assign sticky     = |pn[MAN_W-2:0];
  assign inexact    = guard | rnd | sticky;

  always_comb begin
    inc = 1'b0;
    case (s1_mode)
      3'd1:    inc = 1'b0;                     // toward zero
      3'd2:    inc = inexact & ~s1_sign;       // toward +inf
      3'd3:    inc = inexact & s1_sign;        // toward -inf
      3'd4:    inc = guard;                    // nearest, ties away
      default: inc = guard & (rnd | sticky | kept[0]);  // nearest-even
    endcase
  end

  assign mant_r = {1'b0, kept} + (SW + 1)'(inc);
  // Rounding carry out of the significand leaves 1.000..0: fraction zero, exponent +1.
  assign carry  = mant_r[SW];
  assign frac_r = carry ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
  assign exp_r  = s1_exp + XW'(norm_shift) + XW'(carry);

  logic             s2_valid, s2_spec, s2_spec_ov, s2_spec_ud, s2_sign;
  logic [W-1:0]     s2_spec_z;
  logic [XW-1:0]    s2_exp;
  logic [MAN_W-1:0] s2_frac;
  logic [2:0]       s2_mode;

  // ---------------- S3: pack, flags ----------------
  logic [W-1:0] z_n;
  logic         ov_n, ud_n, to_inf;

  always_comb begin
    z_n    = '0;
    ov_n   = 1'b0;
    ud_n   = 1'b0;
    to_inf = 1'b1;
    if (s2_spec) begin
      z_n  = s2_spec_z;
      ov_n = s2_spec_ov;
      ud_n = s2_spec_ud;
    end else if ($signed(s2_exp) >= $signed(EMAX_X)) begin
      ov_n = 1'b1;
      case (s2_mode)
        3'd1:    to_inf = 1'b0;
        3'd2:    to_inf = ~s2_sign;
        3'd3:    to_inf = s2_sign;
        default: to_inf = 1'b1;
      endcase
      z_n = to_inf ? {s2_sign, E_ONES, {MAN_W{1'b0}}} : {s2_sign, E_MAXF, {MAN_W{1'b1}}};
    end else if ($signed(s2_exp) < $signed(ONE_X)) begin
      z_n  = {s2_sign, {(W - 1){1'b0}}};
      ud_n = 1'b1;
    end else begin
      z_n = {s2_sign, s2_exp[EXP_W-1:0], s2_frac};
    end
  end

  // Control and output registers: cleared by reset, which drops any in-flight ops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      fp_Z      <= '0;
      ovrf      <= 1'b0;
      udrf      <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      fp_Z      <= s2_valid ? z_n : '0;
      ovrf      <= s2_valid & ov_n;
      udrf      <= s2_valid & ud_n;
    end
  end

  // Datapath registers: contents only matter when the matching valid is set.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_spec    <= is_nan | is_inf | is_zero;
      s1_spec_z  <= spec_z;
      s1_spec_ov <= spec_ov;
      s1_spec_ud <= spec_ud;
      s1_sign    <= sign;
      s1_exp     <= exp_sum;
      s1_prod    <= prod;
      s1_mode    <= r_mode;
      s2_spec    <= s1_spec;
      s2_spec_z  <= s1_spec_z;
      s2_spec_ov <= s1_spec_ov;
      s2_spec_ud <= s1_spec_ud;
      s2_sign    <= s1_sign;
      s2_exp     <= exp_r;
      s2_frac    <= frac_r;
      s2_mode    <= s1_mode;
    end
  end
endmodule

// File: tb/tb_fp_mul_pipe.sv
module tb_fp_mul_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready, out_valid, out_ready, ovrf, udrf;
  logic [2:0]  r_mode;
  logic [31:0] fp_X, fp_Y, fp_Z;

  logic        p_in_valid, p_in_ready, p_out_valid, p_out_ready, p_ovrf, p_udrf;
  logic [2:0]  p_r_mode;
  logic [15:0] p_X, p_Y, p_Z;

  fp_mul_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .r_mode(r_mode),
    .fp_X(fp_X), .fp_Y(fp_Y), .out_valid(out_valid), .out_ready(out_ready),
    .fp_Z(fp_Z), .ovrf(ovrf), .udrf(udrf)
  );

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n), .in_valid(p_in_valid), .in_ready(p_in_ready), .r_mode(p_r_mode),
    .fp_X(p_X), .fp_Y(p_Y), .out_valid(p_out_valid), .out_ready(p_out_ready),
    .fp_Z(p_Z), .ovrf(p_ovrf), .udrf(p_udrf)
  );

  typedef struct {
    logic [2:0]  m;
    logic [31:0] x, y, z;
    logic        ov, ud;
  } vec_t;

  vec_t vt[$];
  vec_t vh[$];
  int errors = 0;
  int checks = 0;
  logic [31:0] bp_y[5];
  logic [31:0] bp_z[5];

  task automatic add(input logic [2:0] m, input logic [31:0] x, y, z, input logic ov, ud);
    vec_t v;
    v.m = m; v.x = x; v.y = y; v.z = z; v.ov = ov; v.ud = ud;
    vt.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One isolated op on the single-precision instance; the result must show in
  // the third cycle counting the accept cycle, and not earlier.
  task automatic run_one(input string nm, input logic [2:0] m, input logic [31:0] x, y, z,
                         input logic ov, ud);
    @(negedge clk);
    in_valid = 1'b1; r_mode = m; fp_X = x; fp_Y = y;
    @(negedge clk);
    in_valid = 1'b0;
    chk({nm, "_early1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({nm, "_early2"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({nm, "_vld"}, 32'(out_valid), 32'd1);
    chk({nm, "_z"}, fp_Z, z);
    chk({nm, "_ovrf"}, 32'(ovrf), 32'(ov));
    chk({nm, "_udrf"}, 32'(udrf), 32'(ud));
  endtask

  task automatic run_h(input string nm, input logic [2:0] m, input logic [15:0] x, y, z,
                       input logic ov, ud);
    @(negedge clk);
    p_in_valid = 1'b1; p_r_mode = m; p_X = x; p_Y = y;
    @(negedge clk);
    p_in_valid = 1'b0;
    chk({nm, "_early1"}, 32'(p_out_valid), 32'd0);
    @(negedge clk);
    chk({nm, "_early2"}, 32'(p_out_valid), 32'd0);
    @(negedge clk);
    chk({nm, "_vld"}, 32'(p_out_valid), 32'd1);
    chk({nm, "_z"}, 32'(p_Z), 32'(z));
    chk({nm, "_ovrf"}, 32'(p_ovrf), 32'(ov));
    chk({nm, "_udrf"}, 32'(p_udrf), 32'(ud));
  endtask

  initial begin
    int acc, n, seen;
    vec_t v;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; r_mode = 3'd0; fp_X = '0; fp_Y = '0;
    p_in_valid = 1'b0; p_out_ready = 1'b1; p_r_mode = 3'd0; p_X = '0; p_Y = '0;

    // mode, X, Y, expected Z, ovrf, udrf
    add(3'd0, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
    add(3'd0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0, 1'b0);
    add(3'd1, 32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0, 1'b0);
    add(3'd4, 32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0, 1'b0);
    add(3'd2, 32'h3F800001, 32'h3F800001, 32'h3F800003, 1'b0, 1'b0);
    add(3'd3, 32'hBF800001, 32'h3F800001, 32'hBF800003, 1'b0, 1'b0);
    add(3'd2, 32'hBF800001, 32'h3F800001, 32'hBF800002, 1'b0, 1'b0);
    add(3'd0, 32'h3F800003, 32'h3FC00000, 32'h3FC00004, 1'b0, 1'b0); // tie, even LSB
    add(3'd4, 32'h3F800003, 32'h3FC00000, 32'h3FC00005, 1'b0, 1'b0);
    add(3'd2, 32'h3F800003, 32'h3FC00000, 32'h3FC00005, 1'b0, 1'b0);
    add(3'd5, 32'h3F800003, 32'h3FC00000, 32'h3FC00004, 1'b0, 1'b0);
    add(3'd0, 32'h3F800001, 32'h40400000, 32'h40400002, 1'b0, 1'b0); // tie, odd LSB
    add(3'd1, 32'h3F800001, 32'h40400000, 32'h40400001, 1'b0, 1'b0);
    add(3'd0, 32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 1'b0, 1'b0); // rounding carry
    add(3'd1, 32'h3FFFFFFE, 32'h3F800001, 32'h3FFFFFFF, 1'b0, 1'b0);
    add(3'd0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0);
    add(3'd1, 32'h7F000000, 32'h7F000000, 32'h7F7FFFFF, 1'b1, 1'b0);
    add(3'd3, 32'h7F000000, 32'h7F000000, 32'h7F7FFFFF, 1'b1, 1'b0);
    add(3'd2, 32'hFF000000, 32'h7F000000, 32'hFF7FFFFF, 1'b1, 1'b0);
    add(3'd3, 32'hFF000000, 32'h7F000000, 32'hFF800000, 1'b1, 1'b0);
    add(3'd0, 32'h7F7FFFFF, 32'h3F800001, 32'h7F800000, 1'b1, 1'b0); // exp 255 reached after normalise
    add(3'd0, 32'h00800000, 32'h3F000000, 32'h00000000, 1'b0, 1'b1);
    add(3'd0, 32'h00800000, 32'h3F800000, 32'h00800000, 1'b0, 1'b0); // smallest normal survives
    add(3'd0, 32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b1); // denormal flushed
    add(3'd0, 32'h80000000, 32'h40000000, 32'h80000000, 1'b0, 1'b1);
    add(3'd0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0);
    add(3'd0, 32'hFF800000, 32'h40000000, 32'hFF800000, 1'b1, 1'b0);
    add(3'd0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0);
    add(3'd0, 32'hFF800000, 32'hFF800000, 32'h7F800000, 1'b1, 1'b0);
    add(3'd6, 32'hFFC00000, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0);

    v.m = 3'd0; v.x = 32'h3E00; v.y = 32'h4000; v.z = 32'h4200; v.ov = 1'b0; v.ud = 1'b0; vh.push_back(v);
    v.m = 3'd0; v.x = 32'h7800; v.y = 32'h7800; v.z = 32'h7C00; v.ov = 1'b1; v.ud = 1'b0; vh.push_back(v);
    v.m = 3'd2; v.x = 32'h3C01; v.y = 32'h3C01; v.z = 32'h3C03; v.ov = 1'b0; v.ud = 1'b0; vh.push_back(v);

    // X = 2.0 doubles Y exactly
    bp_y[0] = 32'h3F800000; bp_z[0] = 32'h40000000;
    bp_y[1] = 32'h3FC00000; bp_z[1] = 32'h40400000;
    bp_y[2] = 32'h40000000; bp_z[2] = 32'h40800000;
    bp_y[3] = 32'h40200000; bp_z[3] = 32'h40A00000;
    bp_y[4] = 32'h40400000; bp_z[4] = 32'h40C00000;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_fp_Z", fp_Z, 32'd0);
    chk("rst_ovrf", 32'(ovrf), 32'd0);
    chk("rst_udrf", 32'(udrf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    foreach (vt[i])
      run_one($sformatf("vec%0d", i), vt[i].m, vt[i].x, vt[i].y, vt[i].z, vt[i].ov, vt[i].ud);

    // Backpressure: stalled output, five ops offered back to back
    @(negedge clk);
    out_ready = 1'b0; r_mode = 3'd0; fp_X = 32'h40000000;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      if (acc < 5) begin
        in_valid = 1'b1; fp_Y = bp_y[acc];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk($sformatf("bp_in_ready_c%0d", c), 32'(in_ready), (c < 3) ? 32'd1 : 32'd0);
      if (c >= 3) begin
        chk($sformatf("bp_hold_vld_c%0d", c), 32'(out_valid), 32'd1);
        chk($sformatf("bp_hold_z_c%0d", c), fp_Z, bp_z[0]);
      end
      if (in_valid && in_ready) acc++;
      @(negedge clk);
    end
    chk("bp_accepted", 32'(acc), 32'd3);

    out_ready = 1'b1;
    #1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        if (n < 5) chk($sformatf("bp_order%0d", n), fp_Z, bp_z[n]);
        n++;
      end
      if (acc < 5) begin
        in_valid = 1'b1; fp_Y = bp_y[acc];
        if (in_ready) acc++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      #1;
    end
    chk("bp_result_count", 32'(n), 32'd5);

    // Reset with three ops in flight during a stall
    @(negedge clk);
    out_ready = 1'b0; r_mode = 3'd0;
    in_valid = 1'b1; fp_X = 32'h7F000000; fp_Y = 32'h7F000000;
    @(negedge clk);
    fp_X = 32'h00800000; fp_Y = 32'h3F000000;
    @(negedge clk);
    fp_X = 32'h3FC00000; fp_Y = 32'h40000000;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rs_pre_vld", 32'(out_valid), 32'd1);
    chk("rs_pre_ovrf", 32'(ovrf), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rs_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rs_vld", 32'(out_valid), 32'd0);
    chk("rs_z", fp_Z, 32'd0);
    chk("rs_ovrf", 32'(ovrf), 32'd0);
    chk("rs_udrf", 32'(udrf), 32'd0);
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rs_no_leak", 32'(seen), 32'd0);
    run_one("rs_new", 3'd0, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);

    // Half-precision-shaped instance
    foreach (vh[i])
      run_h($sformatf("half%0d", i), vh[i].m, vh[i].x[15:0], vh[i].y[15:0], vh[i].z[15:0],
            vh[i].ov, vh[i].ud);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp_mul_pipe.md
# fp_mul_pipe

Parametrised, fully pipelined IEEE-754-style floating-point multiplier. It is the next generation of the team's single-precision multiplier DUT: exponent and mantissa widths are configurable, it adds a valid/ready handshake with backpressure and five rounding modes, and it handles special operands completely. It sits behind the same `r_mode`/`fp_X`/`fp_Y` → `fp_Z`/`ovrf`/`udrf` bus that the verification interface drives. Its flag convention matches the existing overflow/underflow assertions.

## Interface
- `EXP_W`, 8, exponent field width (≥3); bias = 2^(EXP_W-1)-1
- `MAN_W`, 23, stored fraction width (≥2); word width W = 1+EXP_W+MAN_W
- `clk` input 1: the single clock; all state updates on its rising edge
- `rst_n` input 1: reset, synchronous, active-low
- `in_valid` input 1: operands and mode present
- `in_ready` output 1: block can accept; transfer when `in_valid & in_ready`
- `r_mode` input 3: rounding mode, sampled with the operands
- `fp_X`, `fp_Y` input W: operands {sign, exponent, fraction}
- `out_valid` output 1: `fp_Z` and flags valid
- `out_ready` input 1: consumer accepts the result when `out_valid & out_ready`
- `fp_Z` output W: product
- `ovrf` output 1: overflow flag, qualified by `out_valid`
- `udrf` output 1: underflow flag, qualified by `out_valid`

## Operation
- **Rounding modes (`r_mode`):**
  - 0: nearest-even.
  - 1: toward zero.
  - 2: toward +inf.
  - 3: toward -inf.
  - 4: nearest, ties away.
  - 5–7: behave as 0.
  - Directed modes act on the signed value. A negative result under mode 2 truncates its magnitude.
- **Sign:** sign = X.s ^ Y.s for every result, including zero and inf. NaN output sign is 0.
- **Denormal inputs:** exponent field 0 is treated as signed zero (flush-to-zero).
- **Special cases, resolved in S1 and bypassing the arithmetic:**
  - Any NaN operand, or inf×zero → canonical qNaN: exponent all ones, fraction MSB 1, rest 0. ovrf=0, udrf=0.
  - inf×(nonzero finite or inf) → ±inf, ovrf=1.
  - zero×(finite) → ±0, udrf=1.
- **Finite path:**
  - Significands of MAN_W+1 bits are multiplied into a 2·(MAN_W+1)-bit product.
  - Exponent sum = eX+eY−bias, computed signed in EXP_W+2 bits.
  - Product MSB set → shift right by 1 and exponent +1.
  - Guard and round bits are taken; sticky = OR of the remaining bits.
  - Mantissa overflow caused by rounding renormalises and adds 1 to the exponent.
- **Overflow:** final exponent ≥ 2^EXP_W−1 → ovrf=1.
  - Result is ±inf for modes 0 and 4.
  - Result is ±max-finite (exp 2^EXP_W−2, fraction all ones) for mode 1.
  - Mode 2: +inf when positive, −max-finite when negative. Mode 3 mirrors this.
- **Underflow:** final exponent ≤ 0 → ±0 with udrf=1. No subnormal outputs.
- **Flag invariant, required by the checker:** udrf=1 exactly when `fp_Z` exponent field is 0. ovrf=1 whenever `fp_Z` is ±inf or an overflow saturated to max-finite. Both flags are 0 otherwise.

## Timing
- **Pipeline:** 3 registered stages. S1: unpack, special detect, mantissa multiply. S2: normalise, round. S3: pack and flags, which feed the output registers directly.
- **Advance enable:** en = ~out_valid | out_ready.
  - `in_ready` = en while `rst_n`=1, and 0 during reset.
  - Every stage advances only when en=1. Bubbles are carried and not collapsed.
- **Latency:** exactly 3 cycles from the accept edge to `out_valid` when en stays 1. Throughput is 1 result/cycle.
- **Backpressure:** while `out_valid & ~out_ready`, `fp_Z`, `ovrf`, `udrf` and `out_valid` hold stable. Maximum occupancy is 3 operations.
- **Ordering:** results leave in acceptance order, with no loss and no duplication.
- **Reset:** a `rst_n`=0 sample at a rising edge clears all stage valids.
  - Sets `out_valid`=0, `fp_Z`=0, `ovrf`=0, `udrf`=0.
  - In-flight operations are discarded, including mid-stall.
  - The first accept is possible at the first edge with `rst_n`=1.
- **Simultaneous events:** accept and output handshake in the same cycle is normal streaming. When `out_ready` rises while `in_valid`=1, both transfers occur at that edge.

## Test plan
- **Basic multiply:** reset, then 0x3FC00000×0x40000000, mode 0, `out_ready`=1 → `fp_Z`=0x40400000, flags 0, `out_valid` 3 cycles after accept.
- **Rounding:** 0x3F800001×0x3F800001 → 0x3F800002 under modes 0, 1 and 4; 0x3F800003 under mode 2. With X sign set (0xBF800001), mode 3 → 0xBF800003.
- **Overflow/underflow:**
  - 0x7F000000×0x7F000000: mode 0 → 0x7F800000 with ovrf=1; mode 1 → 0x7F7FFFFF with ovrf=1.
  - 0x00800000×0x3F000000 → 0x00000000 with udrf=1.
- **Specials:**
  - 0x7F800000×0x00000000 → 0x7FC00000, flags 0.
  - 0xFF800000×0x40000000 → 0xFF800000, ovrf=1.
  - 0x7FC00001×0x3F800000 → 0x7FC00000.
- **Backpressure:**
  - Hold `out_ready`=0 and drive 5 back-to-back ops → exactly 3 accepted; `in_ready`=0 from cycle 3; `fp_Z` stable.
  - Release `out_ready` → 5 results in order.
- **Reset mid-stream:** 3 ops in flight, `rst_n`=0 for one edge → `out_valid`=0, outputs 0, none of the 3 ops emerge. A new op afterwards yields the correct result 3 cycles after accept.
- **Parametrisation:** EXP_W=5, MAN_W=10: 0x3E00×0x4000 → 0x4200, flags 0, same latency.
